// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the AHB-Lite master-port scheduler.
//   owner_t      : requester identity for address/data phase ownership
//   HADDRSEL_*   : address-mux select encodings
//   STARVE_W     : width of the F starvation counter
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_T    = 2'd1,
    OWN_M    = 2'd2,
    OWN_F    = 2'd3
  } owner_t;

  localparam logic [1:0] HADDRSEL_T = 2'b00;
  localparam logic [1:0] HADDRSEL_M = 2'b01;
  localparam logic [1:0] HADDRSEL_F = 2'b10;

  localparam int unsigned STARVE_W = 4;

  // Address-mux select for a grant; idle parks on the F encoding.
  function automatic logic [1:0] owner_to_sel(input owner_t o);
    logic [1:0] sel;
    sel = HADDRSEL_F;
    case (o)
      OWN_T:   sel = HADDRSEL_T;
      OWN_M:   sel = HADDRSEL_M;
      default: sel = HADDRSEL_F;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ahb_prio_pick.sv
// Fixed-priority picker T > M > F with an F starvation override.
//   eligible   in  3  {F, M, T} requesters allowed to take the address phase
//   f_override in  1  F has been starved long enough to jump the queue
//   pick       out    chosen requester, OWN_NONE when nothing is eligible
module ahb_prio_pick
  import ahb_arb_pkg::*;
(
  input  logic [2:0] eligible,
  input  logic       f_override,
  output owner_t     pick
);

  always_comb begin
    pick = OWN_NONE;
    if (f_override && eligible[2]) begin
      pick = OWN_F;
    end else if (eligible[0]) begin
      pick = OWN_T;
    end else if (eligible[1]) begin
      pick = OWN_M;
    end else if (eligible[2]) begin
      pick = OWN_F;
    end
  end

endmodule

// File: rtl/ahb_bus_scheduler.sv
// Sequencer for the shared AHB-Lite master port (walker T, dcache M, icache F).
// Picks one requester per address phase, holds it across wait states, tracks
// the data-phase owner and steers HREADY / read data back to that requester.
//   clk, reset                     clock, synchronous active-high reset
//   HRequestT/M/F, HWriteM         requester handshakes (held until HReadyX)
//   HReady                         bus HREADY
//   HAddrSel, HRequest, HWrite     address-phase controls (no path from HReady)
//   HReadyT/M/F                    per-requester data-phase completion
//   TSel/MSel/FSel                 per-requester data-phase ownership
module ahb_bus_scheduler
  import ahb_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       HRequestT,
  input  logic       HRequestM,
  input  logic       HRequestF,
  input  logic       HWriteM,
  input  logic       HReady,
  output logic [1:0] HAddrSel,
  output logic       HRequest,
  output logic       HWrite,
  output logic       HReadyT,
  output logic       HReadyM,
  output logic       HReadyF,
  output logic       TSel,
  output logic       MSel,
  output logic       FSel
);

  owner_t                downer;
  owner_t                aowner;
  logic                  lock;
  logic [STARVE_W-1:0]   starve;

  logic [2:0]            eligible;
  logic                  f_override;
  owner_t                pick;
  owner_t                grant;

  // A requester already in its data phase must not be reissued.
  assign eligible = {HRequestF && (downer != OWN_F),
                     HRequestM && (downer != OWN_M),
                     HRequestT && (downer != OWN_T)};

  assign f_override = (starve >= STARVE_W'(STARVE_LIMIT));

  ahb_prio_pick u_pick (
    .eligible   (eligible),
    .f_override (f_override),
    .pick       (pick)
  );

  // A presented-but-stalled address phase keeps its owner until accepted.
  assign grant = lock ? aowner : pick;

  // Bus-facing outputs; everything forced quiet while reset is high.
  always_comb begin
    HRequest = 1'b0;
    HAddrSel = HADDRSEL_F;
    HWrite   = 1'b0;
    HReadyT  = 1'b0;
    HReadyM  = 1'b0;
    HReadyF  = 1'b0;
    TSel     = 1'b0;
    MSel     = 1'b0;
    FSel     = 1'b0;
    if (!reset) begin
      HRequest = (grant != OWN_NONE);
      HAddrSel = owner_to_sel(grant);
      HWrite   = (grant == OWN_M) && HWriteM;
      TSel     = (downer == OWN_T);
      MSel     = (downer == OWN_M);
      FSel     = (downer == OWN_F);
      HReadyT  = HReady && (downer == OWN_T);
      HReadyM  = HReady && (downer == OWN_M);
      HReadyF  = HReady && (downer == OWN_F);
    end
  end

  // Ownership, address lock and F starvation tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      downer <= OWN_NONE;
      aowner <= OWN_NONE;
      lock   <= 1'b0;
      starve <= '0;
    end else if (HReady) begin
      downer <= grant;
      aowner <= OWN_NONE;
      lock   <= 1'b0;
      if ((grant == OWN_F) || !HRequestF) begin
        starve <= '0;
      end else if (((grant == OWN_T) || (grant == OWN_M)) && (starve != '1)) begin
        starve <= starve + STARVE_W'(1);
      end
    end else if (grant != OWN_NONE) begin
      lock   <= 1'b1;
      aowner <= grant;
    end
  end

endmodule

// File: tb/tb_ahb_bus_scheduler.sv
// Directed bench for ahb_bus_scheduler. Inputs change just after the falling
// edge; outputs are checked 1 time unit later, well before the next rising edge.
module tb_ahb_bus_scheduler;

  logic       clk;
  logic       reset;
  logic       HRequestT, HRequestM, HRequestF, HWriteM, HReady;
  logic [1:0] HAddrSel;
  logic       HRequest, HWrite;
  logic       HReadyT, HReadyM, HReadyF;
  logic       TSel, MSel, FSel;

  int n_cmp = 0;
  int n_err = 0;

  ahb_bus_scheduler #(.STARVE_LIMIT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .HRequestT (HRequestT),
    .HRequestM (HRequestM),
    .HRequestF (HRequestF),
    .HWriteM   (HWriteM),
    .HReady    (HReady),
    .HAddrSel  (HAddrSel),
    .HRequest  (HRequest),
    .HWrite    (HWrite),
    .HReadyT   (HReadyT),
    .HReadyM   (HReadyM),
    .HReadyF   (HReadyF),
    .TSel      (TSel),
    .MSel      (MSel),
    .FSel      (FSel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle and apply inputs.
  task automatic cyc(input logic rst, input logic t, input logic m,
                     input logic f, input logic w, input logic rdy);
    @(negedge clk);
    reset     = rst;
    HRequestT = t;
    HRequestM = m;
    HRequestF = f;
    HWriteM   = w;
    HReady    = rdy;
    #1;
  endtask

  // Compare all outputs: {HRequest, HAddrSel, HWrite, HReady{T,M,F}, {T,M,F}Sel}.
  task automatic chk(input string tag, input logic req, input logic [1:0] sel,
                     input logic wr, input logic [2:0] rdy, input logic [2:0] xs);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {HRequest, HAddrSel, HWrite, HReadyT, HReadyM, HReadyF, TSel, MSel, FSel};
    exp = {req, sel, wr, rdy, xs};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compare only the address-phase controls.
  task automatic chk_addr(input string tag, input logic req, input logic [1:0] sel);
    logic [2:0] obs;
    logic [2:0] exp;
    obs = {HRequest, HAddrSel};
    exp = {req, sel};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; HRequestT = 1'b0; HRequestM = 1'b0; HRequestF = 1'b0;
    HWriteM = 1'b0; HReady = 1'b1;

    // Reset forces outputs even with a live request.
    cyc(1, 1, 0, 0, 0, 1); chk("rst_forced", 0, 2'b10, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 0, 1); chk("idle_after_rst", 0, 2'b10, 0, 3'b000, 3'b000);

    // M read, zero wait.
    cyc(0, 0, 1, 0, 0, 1); chk("m_rd_addr", 1, 2'b01, 0, 3'b000, 3'b000);
    cyc(0, 0, 1, 0, 0, 1); chk("m_rd_data", 0, 2'b10, 0, 3'b010, 3'b010);
    cyc(0, 0, 0, 0, 0, 1); chk("m_rd_idle", 0, 2'b10, 0, 3'b000, 3'b000);

    // T, M, F together from idle: granted in order.
    cyc(0, 1, 1, 1, 0, 1); chk("tmf_c1", 1, 2'b00, 0, 3'b000, 3'b000);
    cyc(0, 1, 1, 1, 0, 1); chk("tmf_c2", 1, 2'b01, 0, 3'b100, 3'b100);
    cyc(0, 0, 1, 1, 0, 1); chk("tmf_c3", 1, 2'b10, 0, 3'b010, 3'b010);
    cyc(0, 0, 0, 1, 0, 1); chk("tmf_c4", 0, 2'b10, 0, 3'b001, 3'b001);
    cyc(0, 0, 0, 0, 0, 1); chk("tmf_idle", 0, 2'b10, 0, 3'b000, 3'b000);

    // Wait states: M held stable while T waits.
    cyc(0, 0, 1, 0, 0, 0); chk("ws_c1", 1, 2'b01, 0, 3'b000, 3'b000);
    cyc(0, 1, 1, 0, 0, 0); chk("ws_c2", 1, 2'b01, 0, 3'b000, 3'b000);
    cyc(0, 1, 1, 0, 0, 0); chk("ws_c3", 1, 2'b01, 0, 3'b000, 3'b000);
    cyc(0, 1, 1, 0, 0, 1); chk("ws_c4", 1, 2'b01, 0, 3'b000, 3'b000);
    cyc(0, 1, 1, 0, 0, 1); chk("ws_c5", 1, 2'b00, 0, 3'b010, 3'b010);
    cyc(0, 1, 0, 0, 0, 1); chk("ws_c6", 0, 2'b10, 0, 3'b100, 3'b100);
    cyc(0, 0, 0, 0, 0, 1); chk("ws_idle", 0, 2'b10, 0, 3'b000, 3'b000);

    // Starvation: T and M alternate, F wins the 9th accepted phase.
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 1, 1, 0, 1);
      chk_addr($sformatf("starve_c%0d", k), 1, (k % 2 == 1) ? 2'b00 : 2'b01);
    end
    cyc(0, 1, 1, 1, 0, 1); chk("starve_c9_f", 1, 2'b10, 0, 3'b010, 3'b010);
    // Counter restarted: F completes, then 8 more T/M wins before F again.
    cyc(0, 1, 1, 1, 0, 1); chk("starve_c10", 1, 2'b00, 0, 3'b001, 3'b001);
    for (int k = 11; k <= 17; k++) begin
      cyc(0, 1, 1, 1, 0, 1);
      chk_addr($sformatf("starve_c%0d", k), 1, (k % 2 == 1) ? 2'b01 : 2'b00);
    end
    cyc(0, 1, 1, 1, 0, 1); chk("starve_c18_f", 1, 2'b10, 0, 3'b010, 3'b010);
    cyc(0, 1, 1, 1, 0, 1); chk("starve_c19", 1, 2'b00, 0, 3'b001, 3'b001);
    cyc(0, 1, 0, 0, 0, 1); chk("starve_c20", 0, 2'b10, 0, 3'b100, 3'b100);
    cyc(0, 0, 0, 0, 0, 1); chk("starve_idle", 0, 2'b10, 0, 3'b000, 3'b000);

    // M write: HWrite only on the M grant.
    cyc(0, 1, 1, 1, 1, 1); chk("wr_t", 1, 2'b00, 0, 3'b000, 3'b000);
    cyc(0, 1, 1, 1, 1, 1); chk("wr_m", 1, 2'b01, 1, 3'b100, 3'b100);
    cyc(0, 0, 1, 1, 1, 1); chk("wr_f", 1, 2'b10, 0, 3'b010, 3'b010);
    cyc(0, 0, 0, 1, 1, 1); chk("wr_end", 0, 2'b10, 0, 3'b001, 3'b001);
    cyc(0, 0, 0, 0, 0, 1); chk("wr_idle", 0, 2'b10, 0, 3'b000, 3'b000);

    // Reset during a stalled F data phase.
    cyc(0, 0, 0, 1, 0, 1); chk("rst_f_addr", 1, 2'b10, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 1, 0, 0); chk("rst_f_stall", 0, 2'b10, 0, 3'b000, 3'b001);
    cyc(1, 0, 0, 1, 0, 1); chk("rst_mid", 0, 2'b10, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 1, 0, 1); chk("rst_regrant", 1, 2'b10, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 1, 0, 1); chk("rst_f_done", 0, 2'b10, 0, 3'b001, 3'b001);
    cyc(0, 0, 0, 0, 0, 1); chk("final_idle", 0, 2'b10, 0, 3'b000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
